alu_result_fifo: RTL and testbench

Registered output stage directly downstream of the 32-bit ALU logic units (NOT, AND, OR, ADD, …). Captures each ALU result under a valid/ready handshake into a small first-word-fall-through FIFO. Tags every entry with zero and negative flags at write time. Presents results to the writeback/display consumer, which may stall. Counts results dropped while the FIFO is full, for debug.

---
 rtl/alu_result_fifo_pkg.sv | 15 +
 rtl/alu_result_fifo_if.sv | 24 ++
 rtl/alu_flag_gen.sv | 15 +
 rtl/alu_result_fifo.sv | 91 +++++++++
 tb/tb_alu_result_fifo.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_result_fifo_pkg.sv
// Shared definitions for the ALU result FIFO: operand width,
// flag bit positions and occupancy-state encodings.
package alu_result_fifo_pkg;

    localparam int ALU_WIDTH = 32;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;

    // Occupancy condition, decoded from the count register only
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer/consumer handshake bundle around the ALU result FIFO.
// The FIFO uses the slave modport; the ALU/consumer side uses master.
interface alu_result_fifo_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg
    );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative status flags for an ALU result.
module alu_flag_gen
    import alu_result_fifo_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [1:0]       flags_o
);
    always_comb begin
        flags_o            = '0;
        flags_o[FLAG_ZERO] = (data_i == '0);
        flags_o[FLAG_NEG]  = data_i[WIDTH-1];
    end
endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO capturing ALU results with flags,
// plus a saturating counter of refused inputs.
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_result_fifo_if.slave           bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DROP_W-1:0]          drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 2;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [1:0]        state;
    logic [1:0]        flags;
    logic [EW-1:0]     head;
    logic              push, pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .data_i  (bus.in_data),
        .flags_o (flags)
    );

    always_comb begin
        state = ST_PARTIAL;
        if (count_q == '0)
            state = ST_EMPTY;
        else if (count_q == CW'(DEPTH))
            state = ST_FULL;
    end

    assign bus.in_ready  = (state != ST_FULL);
    assign bus.out_valid = (state != ST_EMPTY);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        // Saturate rather than wrap so a long stall stays visible
        if (bus.in_valid && !bus.in_ready && drop_q != '1)
            drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            if (push)
                mem_q[wr_ptr_q] <= {flags, bus.in_data};
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign bus.out_data = head[WIDTH-1:0];
    assign bus.out_zero = head[WIDTH+FLAG_ZERO];
    assign bus.out_neg  = head[WIDTH+FLAG_NEG];
    assign count        = count_q;
    assign drop_cnt     = drop_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo with hand-computed expectations.
module tb_alu_result_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count;
    logic [7:0] drop_cnt;
    int         n_run = 0;
    int         n_fail = 0;

    alu_result_fifo_if #(.WIDTH(32)) bus ();

    alu_result_fifo #(.WIDTH(32), .DEPTH(4), .DROP_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .count    (count),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] v3 [3];
    logic [1:0]  f3 [3];

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        v3 = '{32'h0000_0000, 32'h8000_0001, 32'h0000_FFFF};
        f3 = '{2'b10, 2'b01, 2'b00};

        tick(); tick();
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_out_valid", 64'(bus.out_valid), 64'h0);
            chk("idle_in_ready", 64'(bus.in_ready), 64'h1);
            chk("idle_count", 64'(count), 64'h0);
            chk("idle_drop", 64'(drop_cnt), 64'h0);
        end

        // Three pushes with flags, consumer stalled
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = v3[i];
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t1_count", 64'(count), 64'h3);
        tick();
        chk("t1_stall_head", 64'(bus.out_data), 64'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_valid", 64'(bus.out_valid), 64'h1);
            chk("t1_data", 64'(bus.out_data), 64'(v3[i]));
            chk("t1_zero_neg", 64'({bus.out_zero, bus.out_neg}), 64'(f3[i]));
            tick();
        end
        chk("t1_empty", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 1'b0;

        // Fill, then three refused pushes
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = 32'(i);
            tick();
        end
        bus.in_data = 32'hDEAD;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid = 1'b0;
        chk("t2_in_ready", 64'(bus.in_ready), 64'h0);
        chk("t2_count", 64'(count), 64'h4);
        chk("t2_drop", 64'(drop_cnt), 64'h3);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain", 64'(bus.out_data), 64'(i));
            tick();
        end
        chk("t2_count_end", 64'(count), 64'h0);
        chk("t2_valid_end", 64'(bus.out_valid), 64'h0);

        // Sustained stream through wrapping pointers
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = 32'(i);
            tick();
            chk("t3_count", 64'(count), 64'h1);
            chk("t3_data", 64'(bus.out_data), 64'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t3_count_end", 64'(count), 64'h0);
        chk("t3_drop", 64'(drop_cnt), 64'h3);

        // Full with push and pop together: only the pop happens
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 32'hA0 + 32'(i);
            tick();
        end
        chk("t4_full", 64'(count), 64'h4);
        bus.in_data   = 32'hBB;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t4_count", 64'(count), 64'h3);
        chk("t4_drop", 64'(drop_cnt), 64'h4);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk("t4_drain", 64'(bus.out_data), 64'hA0 + 64'(i));
            tick();
        end
        chk("t4_no_bb", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 1'b0;

        // Reset mid-operation while pushing
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h11;
        tick();
        bus.in_data  = 32'h22;
        tick();
        chk("t5_count_pre", 64'(count), 64'h2);
        rst          = 1'b1;
        bus.in_data  = 32'h5;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_valid", 64'(bus.out_valid), 64'h0);
        chk("t5_count", 64'(count), 64'h0);
        chk("t5_in_ready", 64'(bus.in_ready), 64'h1);
        chk("t5_drop", 64'(drop_cnt), 64'h0);
        bus.out_ready = 1'b1;
        tick(); tick();
        chk("t5_no_5", 64'(bus.out_valid), 64'h0);
        bus.out_ready = 1'b0;

        // Drop counter saturation
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h7;
        for (int i = 0; i < 4 + 260; i++) tick();
        bus.in_valid = 1'b0;
        chk("t6_drop_sat", 64'(drop_cnt), 64'hFF);
        tick();
        chk("t6_drop_hold", 64'(drop_cnt), 64'hFF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
